// File: rtl/vec_pkg.sv
// Shared types and constants for the serial-to-parallel vector pair loader.
package vec_pkg;

    localparam int DW = 5;
    localparam int N  = 4;
    localparam int CW = $clog2(2 * N);

    typedef logic signed [DW-1:0] elem_t;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } ld_state_t;

    function automatic int slot_lsb(input int k);
        return k * DW;
    endfunction

endpackage

// File: rtl/vec_pair_loader.sv
// Collects 2*N signed elements (A0..A3 then B0..B3) and presents them as a
// held register pair until the downstream dot-product unit takes it.
module vec_pair_loader
    import vec_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sop,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] a_vec,
    output logic [N*DW-1:0] b_vec,
    output logic            frame_err,
    output logic [7:0]      frames_done
);

    localparam logic [CW-1:0] LAST_IDX = CW'(2 * N - 1);

    ld_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          frame_err_reg, frame_err_next;
    logic [7:0]    frames_done_reg, frames_done_next;

    logic          accept;
    logic          load_beat;
    logic [CW-1:0] wr_idx;

    assign in_ready    = (state_reg == LOAD) & ~rst;
    assign accept      = in_valid & in_ready;
    assign out_valid   = (state_reg == FULL);
    assign frame_err   = frame_err_reg;
    assign frames_done = frames_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= LOAD;
            cnt_reg         <= '0;
            frame_err_reg   <= 1'b0;
            frames_done_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            frame_err_reg   <= frame_err_next;
            frames_done_reg <= frames_done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        frame_err_next   = 1'b0;
        frames_done_next = frames_done_reg;
        load_beat        = 1'b0;
        wr_idx           = cnt_reg;

        case (state_reg)
            LOAD: begin
                if (accept) begin
                    if (in_sop) begin
                        // A start marker always restarts the frame at A0;
                        // abandoning a partial frame is an error.
                        load_beat      = 1'b1;
                        wr_idx         = '0;
                        cnt_next       = CW'(1);
                        frame_err_next = (cnt_reg != '0);
                    end else if (cnt_reg == '0) begin
                        frame_err_next = 1'b1;
                    end else begin
                        load_beat = 1'b1;
                        if (cnt_reg == LAST_IDX) begin
                            cnt_next   = '0;
                            state_next = FULL;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_next       = LOAD;
                    frames_done_next = frames_done_reg + 8'd1;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // One holding register per element slot; slots are never cleared except
    // by reset, so a restarted frame simply overwrites stale contents.
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        elem_t a_slot_reg;
        elem_t b_slot_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                a_slot_reg <= '0;
                b_slot_reg <= '0;
            end else if (load_beat) begin
                if (wr_idx == CW'(gi)) begin
                    a_slot_reg <= in_data;
                end
                if (wr_idx == CW'(gi + N)) begin
                    b_slot_reg <= in_data;
                end
            end
        end

        assign a_vec[slot_lsb(gi) +: DW] = a_slot_reg;
        assign b_vec[slot_lsb(gi) +: DW] = b_slot_reg;
    end

endmodule

// File: tb/tb_vec_pair_loader.sv
// Directed self-checking bench for vec_pair_loader: framing, back-pressure,
// reset recovery and frames_done wrap over 256 back-to-back frames.
module tb_vec_pair_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sop;
    logic [4:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] a_vec;
    logic [19:0] b_vec;
    logic        frame_err;
    logic [7:0]  frames_done;

    int tests;
    int fails;
    int cyc;

    vec_pair_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sop      (in_sop),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a_vec       (a_vec),
        .b_vec       (b_vec),
        .frame_err   (frame_err),
        .frames_done (frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dot(input logic [19:0] a, input logic [19:0] b);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            logic signed [4:0] ea;
            logic signed [4:0] eb;
            int ia;
            int ib;
            ea = a[k*5 +: 5];
            eb = b[k*5 +: 5];
            ia = ea;
            ib = eb;
            s  = s + ia * ib;
        end
        return s;
    endfunction

    function automatic logic [39:0] pk(input int e0, input int e1, input int e2, input int e3,
                                       input int e4, input int e5, input int e6, input int e7);
        logic [39:0] r;
        r[4:0]   = e0[4:0];
        r[9:5]   = e1[4:0];
        r[14:10] = e2[4:0];
        r[19:15] = e3[4:0];
        r[24:20] = e4[4:0];
        r[29:25] = e5[4:0];
        r[34:30] = e6[4:0];
        r[39:35] = e7[4:0];
        return r;
    endfunction

    // Presents one beat and returns #1 after the edge that consumed it.
    task automatic beat(input logic sop, input logic [4:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_data  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        assert (ok) else begin
            fails++;
            $error("FAIL beat_wait observed=in_ready_low expected=in_ready_high");
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f);
        beat(1'b1, f[4:0]);
        for (int k = 1; k < 8; k++) begin
            beat(1'b0, f[k*5 +: 5]);
        end
    endtask

    logic [19:0] a_hold;
    logic [19:0] b_hold;
    int          prev_handoff;

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a_vec", 32'(a_vec), 32'd0);
        chk("rst_b_vec", 32'(b_vec), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_frames_done", 32'(frames_done), 32'd0);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_high", 32'(in_ready), 32'd1);

        // Frame 1: 1,3,-1,-5 | 2,-2,2,-5 with consumer ready
        send_frame(pk(1, 3, -1, -5, 2, -2, 2, -5));
        chk("f1_out_valid", 32'(out_valid), 32'd1);
        chk("f1_a_vec", 32'(a_vec), 32'({5'h1B, 5'h1F, 5'd3, 5'd1}));
        chk("f1_b_vec", 32'(b_vec), 32'({5'h1B, 5'h02, 5'h1E, 5'd2}));
        chk("f1_in_ready_full", 32'(in_ready), 32'd0);
        chk("f1_dot", 32'(dot(a_vec, b_vec)), 32'd19);
        @(posedge clk);
        #1;
        chk("f1_out_valid_drop", 32'(out_valid), 32'd0);
        chk("f1_frames_done", 32'(frames_done), 32'd1);
        chk("f1_in_ready_after", 32'(in_ready), 32'd1);
        chk("f1_a_kept", 32'(a_vec), 32'({5'h1B, 5'h1F, 5'd3, 5'd1}));
        $display("[TB] frame1 a=%h b=%h frames_done=%0d", a_vec, b_vec, frames_done);

        // Frame 2: consumer stalls for 5 cycles while a beat is presented
        out_ready = 1'b0;
        send_frame(pk(1, 3, 5, 5, 2, 4, 2, 4));
        chk("f2_out_valid", 32'(out_valid), 32'd1);
        chk("f2_dot", 32'(dot(a_vec, b_vec)), 32'd44);
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_data  = 5'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("f2_hold_valid", 32'(out_valid), 32'd1);
            chk("f2_hold_a", 32'(a_vec), 32'({5'd5, 5'd5, 5'd3, 5'd1}));
            chk("f2_hold_b", 32'(b_vec), 32'({5'd4, 5'd2, 5'd4, 5'd2}));
            chk("f2_hold_in_ready", 32'(in_ready), 32'd0);
            chk("f2_hold_done", 32'(frames_done), 32'd1);
        end
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("f2_out_valid_drop", 32'(out_valid), 32'd0);
        chk("f2_frames_done", 32'(frames_done), 32'd2);
        chk("f2_frame_err", 32'(frame_err), 32'd0);
        $display("[TB] frame2 a=%h b=%h frames_done=%0d", a_vec, b_vec, frames_done);

        // Frame 3: restart after 3 beats via a new sop carrying 7
        beat(1'b1, 5'd1);
        beat(1'b0, 5'd2);
        beat(1'b0, 5'd3);
        beat(1'b1, 5'd7);
        chk("f3_err_pulse", 32'(frame_err), 32'd1);
        chk("f3_slot0", 32'(a_vec[4:0]), 32'd7);
        beat(1'b0, 5'd8);
        chk("f3_err_clear", 32'(frame_err), 32'd0);
        for (int v = 9; v <= 14; v++) begin
            chk("f3_not_full", 32'(out_valid), 32'd0);
            beat(1'b0, 5'(v));
        end
        chk("f3_out_valid", 32'(out_valid), 32'd1);
        chk("f3_a_vec", 32'(a_vec), 32'({5'd10, 5'd9, 5'd8, 5'd7}));
        chk("f3_b_vec", 32'(b_vec), 32'({5'd14, 5'd13, 5'd12, 5'd11}));
        @(posedge clk);
        #1;
        chk("f3_frames_done", 32'(frames_done), 32'd3);
        $display("[TB] frame3 a=%h b=%h frames_done=%0d", a_vec, b_vec, frames_done);

        // Frame 4: stray beat without sop at cnt==0 is dropped
        beat(1'b0, 5'd9);
        chk("f4_err_pulse", 32'(frame_err), 32'd1);
        chk("f4_a_unchanged", 32'(a_vec), 32'({5'd10, 5'd9, 5'd8, 5'd7}));
        @(posedge clk);
        #1;
        chk("f4_err_clear", 32'(frame_err), 32'd0);
        send_frame(pk(-16, 15, 0, -1, 1, -1, 1, -1));
        chk("f4_out_valid", 32'(out_valid), 32'd1);
        chk("f4_a_vec", 32'(a_vec), 32'({5'h1F, 5'h00, 5'h0F, 5'h10}));
        chk("f4_b_vec", 32'(b_vec), 32'({5'h1F, 5'h01, 5'h1F, 5'h01}));
        chk("f4_dot", 32'(dot(a_vec, b_vec)), 32'hFFFFFFE2);
        @(posedge clk);
        #1;
        chk("f4_frames_done", 32'(frames_done), 32'd4);
        $display("[TB] frame4 a=%h b=%h frames_done=%0d", a_vec, b_vec, frames_done);

        // Reset at beat 5 of a frame
        beat(1'b1, 5'd1);
        for (int v = 2; v <= 5; v++) beat(1'b0, 5'(v));
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'd6;
        @(posedge clk);
        #1;
        chk("rst_mid_a", 32'(a_vec), 32'd0);
        chk("rst_mid_b", 32'(b_vec), 32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_done", 32'(frames_done), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_mid_ready_after", 32'(in_ready), 32'd1);
        $display("[TB] reset mid-frame a=%h b=%h frames_done=%0d", a_vec, b_vec, frames_done);

        // Reset while holding a full pair
        out_ready = 1'b0;
        send_frame(pk(3, 3, 3, 3, 3, 3, 3, 3));
        chk("rst_full_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_full_valid", 32'(out_valid), 32'd0);
        chk("rst_full_a", 32'(a_vec), 32'd0);
        chk("rst_full_b", 32'(b_vec), 32'd0);
        chk("rst_full_err", 32'(frame_err), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_full_ready_after", 32'(in_ready), 32'd1);
        $display("[TB] reset in FULL a=%h b=%h frames_done=%0d", a_vec, b_vec, frames_done);

        // 256 back-to-back frames: frames_done wraps, handoffs 9 cycles apart
        prev_handoff = 0;
        for (int i = 0; i < 256; i++) begin
            send_frame(pk(i, 1, 2, 3, 4, 5, 6, 7));
            chk("wrap_valid", 32'(out_valid), 32'd1);
            chk("wrap_slot0", 32'(a_vec[4:0]), 32'(i % 32));
            @(posedge clk);
            #1;
            chk("wrap_valid_1cyc", 32'(out_valid), 32'd0);
            chk("wrap_done", 32'(frames_done), 32'((i + 1) % 256));
            if (i > 0) chk("wrap_spacing", 32'(cyc - prev_handoff), 32'd9);
            prev_handoff = cyc;
            $display("[TB] wrap frame %0d a=%h frames_done=%0d", i, a_vec, frames_done);
        end
        chk("wrap_final_zero", 32'(frames_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
